// File: rtl/ps2_key_buffer.sv
// ps2_key_buffer
//   PS/2 keyboard receiver with make-code FIFO for the CPU keyboard port.
//   Synchronises the raw PS/2 pins, deframes 11-bit frames (start, 8 data
//   LSB first, odd parity, stop), filters E0/F0 prefixes and break codes,
//   and queues make codes. One entry is popped per CPU read strobe.
// Ports
//   CLK              system clock, all logic on rising edge
//   resetn           synchronous reset, active low
//   ps2_clk          raw PS/2 clock pin (asynchronous)
//   ps2_data         raw PS/2 data pin (asynchronous)
//   clean_key_buffer CPU key-read strobe; may stay high several cycles
//   pressed_key      FIFO head make code, 8'h00 when empty
//   keyboard_valid   FIFO not empty
//   overflow         sticky: a code was dropped because the FIFO was full
//   frame_error      one-cycle pulse: frame discarded (start/parity/stop/timeout)
module ps2_key_buffer #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 12000
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       clean_key_buffer,
  output logic [7:0] pressed_key,
  output logic       keyboard_valid,
  output logic       overflow,
  output logic       frame_error
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Pin synchronisers
  logic clk_s1, clk_s2, clk_prev, data_s1, data_s2;
  logic fall, bit_in;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
    end
  end

  assign fall   = clk_prev & ~clk_s2;
  assign bit_in = data_s2;

  // Receive FSM
  rx_state_t       state, state_next;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift_reg;
  logic            par_bit;
  logic [TW-1:0]   to_cnt;
  logic            timeout_hit, byte_done, frame_ok, err_now;

  assign timeout_hit = (state != IDLE) && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (timeout_hit) begin
      state_next = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!bit_in) state_next = DATA;
        DATA:    if (bit_cnt == 3'd7) state_next = PARITY;
        PARITY:  state_next = STOP;
        STOP:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    byte_done = (state == STOP) && fall;
    frame_ok  = byte_done && bit_in && (^{shift_reg, par_bit});
    err_now   = (byte_done && !frame_ok) || timeout_hit;
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      par_bit     <= 1'b0;
      to_cnt      <= '0;
      frame_error <= 1'b0;
    end else begin
      frame_error <= err_now;
      if (fall || state == IDLE) to_cnt <= '0;
      else                       to_cnt <= to_cnt + TW'(1);
      if (state == IDLE) bit_cnt <= '0;
      if (fall && state == DATA) begin
        shift_reg <= {bit_in, shift_reg[7:1]};
        bit_cnt   <= bit_cnt + 3'd1;
      end
      if (fall && state == PARITY) par_bit <= bit_in;
    end
  end

  // Prefix filter: E0 only counts as a prefix when no break is pending
  logic brk, ext;
  logic is_e0, is_f0, push_req;

  assign is_e0    = (shift_reg == 8'hE0);
  assign is_f0    = (shift_reg == 8'hF0);
  assign push_req = frame_ok && !brk && !is_e0 && !is_f0;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      brk <= 1'b0;
      ext <= 1'b0;
    end else if (frame_ok) begin
      if (brk) begin
        if (!is_f0) begin
          brk <= 1'b0;
          ext <= 1'b0;
        end
      end else if (is_e0) begin
        ext <= 1'b1;
      end else if (is_f0) begin
        brk <= 1'b1;
      end else begin
        ext <= 1'b0;
      end
    end
  end

  // Key FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          pop_armed, pop, push_ok, full;

  assign keyboard_valid = (count != '0);
  assign full           = (count == CW'(FIFO_DEPTH));
  assign pop            = pop_armed && clean_key_buffer && keyboard_valid;
  assign push_ok        = push_req && (!full || pop);
  assign pressed_key    = keyboard_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      pop_armed <= 1'b1;
    end else begin
      // Any strobe-high cycle disarms; a low cycle rearms
      pop_armed <= !clean_key_buffer;
      if (push_req && !push_ok) overflow <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= shift_reg;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

endmodule

// File: tb/tb_ps2_key_buffer.sv
module tb_ps2_key_buffer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 300;
  localparam int          HALF    = 10;

  logic       CLK = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       clean_key_buffer = 1'b0;
  logic [7:0] pressed_key;
  logic       keyboard_valid, overflow, frame_error;

  ps2_key_buffer #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .CLK(CLK), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .clean_key_buffer(clean_key_buffer), .pressed_key(pressed_key),
    .keyboard_valid(keyboard_valid), .overflow(overflow), .frame_error(frame_error)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;
  int err_cnt = 0;
  int lat;

  // Scoreboard model
  logic [7:0] mq[$];
  bit m_brk, m_ext, m_ovf;

  always @(negedge CLK) if (frame_error === 1'b1) err_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] m_head();
    return (mq.size() != 0) ? mq[0] : 8'h00;
  endfunction

  function automatic logic m_valid();
    return (mq.size() != 0);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (m_brk) begin
      if (b != 8'hF0) begin m_brk = 0; m_ext = 0; end
    end else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      m_ext = 0;
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1;
    end
  endtask

  // Drives the first n bits of a frame; n=11 is a full frame
  task automatic send_bits(input logic [7:0] b, input bit flip, input int n);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    lat = -1;
    for (int k = 0; k < n; k++) begin
      ps2_data = bits[k];
      wait_clk(HALF);
      ps2_clk = 1'b0;
      for (int i = 1; i <= HALF; i++) begin
        @(negedge CLK);
        if (k == 10 && keyboard_valid && lat < 0) lat = i;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip);
    send_bits(b, flip, 11);
    if (!flip) model_rx(b);
  endtask

  task automatic strobe(input int n);
    clean_key_buffer = 1'b1;
    wait_clk(n);
    clean_key_buffer = 1'b0;
    wait_clk(1);
    if (mq.size() != 0) void'(mq.pop_front());
  endtask

  task automatic model_reset();
    mq.delete();
    m_brk = 0; m_ext = 0; m_ovf = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    wait_clk(3);
    resetn = 1'b1;
    model_reset();
    wait_clk(2);
    total++; if (keyboard_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", keyboard_valid); end
    total++; if (pressed_key !== 8'h00) begin bad++; $display("FAIL rst_key got=%h exp=00", pressed_key); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_ferr got=%b exp=0", frame_error); end
  endtask

  task automatic test_single();
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 0);
    total++; if (lat < 1 || lat > 4) begin bad++; $display("FAIL single_latency got=%0d exp=1..4", lat); end
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL single_key got=%h exp=%h", pressed_key, m_head()); end
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL single_valid got=%b exp=%b", keyboard_valid, m_valid()); end
    strobe(1);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL single_pop got=%b exp=%b", keyboard_valid, m_valid()); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL single_ferr got=%0d exp=%0d", err_cnt - e0, 0); end
  endtask

  task automatic test_prefix();
    int e0;
    e0 = err_cnt;
    send_frame(8'hF0, 0); send_frame(8'h1C, 0);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL brk_valid got=%b exp=%b", keyboard_valid, m_valid()); end
    send_frame(8'hE0, 0); send_frame(8'hF0, 0); send_frame(8'h75, 0);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL extbrk_valid got=%b exp=%b", keyboard_valid, m_valid()); end
    send_frame(8'hF0, 0); send_frame(8'hE0, 0);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL brk_e0_valid got=%b exp=%b", keyboard_valid, m_valid()); end
    send_frame(8'hE0, 0); send_frame(8'h75, 0);
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL ext_key got=%h exp=%h", pressed_key, m_head()); end
    total++; if (err_cnt !== e0) begin bad++; $display("FAIL prefix_ferr got=%0d exp=0", err_cnt - e0); end
    strobe(1);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL prefix_pop got=%b exp=%b", keyboard_valid, m_valid()); end
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes = '{8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    for (int i = 0; i < 5; i++) send_frame(codes[i], 0);
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_flag got=%b exp=%b", overflow, m_ovf); end
    for (int i = 0; i < 4; i++) begin
      total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, pressed_key, m_head()); end
      strobe(1);
    end
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL ovf_drain got=%b exp=%b", keyboard_valid, m_valid()); end
    total++; if (overflow !== m_ovf) begin bad++; $display("FAIL ovf_sticky got=%b exp=%b", overflow, m_ovf); end
  endtask

  task automatic test_long_strobe();
    send_frame(8'h2A, 0); send_frame(8'h2B, 0);
    strobe(5);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL long_valid got=%b exp=%b", keyboard_valid, m_valid()); end
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL long_key got=%h exp=%h", pressed_key, m_head()); end
    strobe(2);
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL long_second got=%b exp=%b", keyboard_valid, m_valid()); end
    strobe(1);
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL empty_strobe got=%h exp=%h", pressed_key, m_head()); end
  endtask

  task automatic test_errors();
    int e0;
    send_frame(8'h22, 0);
    e0 = err_cnt;
    send_frame(8'h5A, 1);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL parity_err got=%0d exp=1", err_cnt - e0); end
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL parity_fifo got=%h exp=%h", pressed_key, m_head()); end
    e0 = err_cnt;
    send_bits(8'h3C, 0, 4);
    wait_clk(TIMEOUT / 2);
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL timeout_early got=%0d exp=0", err_cnt - e0); end
    wait_clk(TIMEOUT);
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL timeout_err got=%0d exp=1", err_cnt - e0); end
    send_frame(8'h33, 0);
    strobe(1);
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL after_timeout got=%h exp=%h", pressed_key, m_head()); end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h44, 0); send_frame(8'h45, 0);
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL pre_rst_key got=%h exp=%h", pressed_key, m_head()); end
    send_bits(8'h6B, 0, 3);
    resetn = 1'b0;
    wait_clk(1);
    model_reset();
    total++; if (keyboard_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", keyboard_valid); end
    total++; if (pressed_key !== 8'h00) begin bad++; $display("FAIL midrst_key got=%h exp=00", pressed_key); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL midrst_ovf got=%b exp=0", overflow); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL midrst_ferr got=%b exp=0", frame_error); end
    resetn = 1'b1;
    wait_clk(2);
    send_frame(8'h29, 0);
    total++; if (pressed_key !== m_head()) begin bad++; $display("FAIL post_rst_key got=%h exp=%h", pressed_key, m_head()); end
    total++; if (keyboard_valid !== m_valid()) begin bad++; $display("FAIL post_rst_valid got=%b exp=%b", keyboard_valid, m_valid()); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_prefix();
    test_overflow();
    test_long_strobe();
    test_errors();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
